// File: rtl/i2c_rxfifo_wrctl.sv
// ---------------------------------------------------------------------------
// i2c_rxfifo_wrctl
// Slave-receive byte sequencer in front of the I2C RX FIFO write port.
// Shifts in SCL-sampled bits MSB first, decides ACK/NACK per byte from the
// FIFO full flag, issues a one-cycle active-low FIFO write strobe per
// accepted byte, and can stretch SCL (bounded) while the FIFO is full.
//
// Ports
//   wr_clk, rst_an        clock / async active-low reset
//   rx_en                 receive enable, low forces IDLE
//   start_det, stop_det   one-cycle START/repeated-START and STOP pulses
//   bit_vld, bit_in       one-cycle bit strobe and sampled SDA value
//   fifo_full             RX FIFO full flag
//   fifo_wr_n, fifo_di    FIFO write strobe (active low) and data
//   ack_drv               1 = pull SDA low during the ACK bit
//   scl_hold              1 = stretch SCL low
//   ovr_pulse             one-cycle pulse per byte dropped because of full
//   ovr_clr, ovr_cnt      dropped-byte counter (saturating) and its clear
//   busy                  1 while not IDLE
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transfer, waiting for START
// SHIFT | collecting data bits of a byte
// HOLD  | byte complete, FIFO full, stretching SCL until space or timeout
// ACK   | byte accepted, driving ACK until the 9th clock
// NACK  | byte dropped, releasing SDA until the 9th clock, then IDLE
// ---------------------------------------------------------------------------
module i2c_rxfifo_wrctl #(
  parameter bit STRETCH_EN  = 1'b1,
  parameter int STRETCH_MAX = 1023,
  parameter int TMO_BITS    = 10
) (
  input  logic       wr_clk,
  input  logic       rst_an,
  input  logic       rx_en,
  input  logic       start_det,
  input  logic       stop_det,
  input  logic       bit_vld,
  input  logic       bit_in,
  input  logic       fifo_full,
  output logic       fifo_wr_n,
  output logic [7:0] fifo_di,
  output logic       ack_drv,
  output logic       scl_hold,
  output logic       ovr_pulse,
  input  logic       ovr_clr,
  output logic [7:0] ovr_cnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_HOLD  = 3'd2,
    S_ACK   = 3'd3,
    S_NACK  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          shreg;
  logic [3:0]          bit_cnt;
  logic [TMO_BITS-1:0] hold_cnt;

  logic                abort;
  logic                byte_end;
  logic                hold_tmo;
  logic                wr_go;
  logic                ovr_go;
  logic [7:0]          wr_data;

  // rx_en low and STOP outrank everything; START outranks bit events.
  assign abort    = ~rx_en | stop_det;
  assign byte_end = (state == S_SHIFT) & bit_vld & (bit_cnt == 4'd7);
  // hold_cnt is 0 in the first HOLD cycle, so this gives STRETCH_MAX cycles of stretch.
  assign hold_tmo = (hold_cnt == TMO_BITS'(STRETCH_MAX - 1));

  always_ff @(posedge wr_clk or negedge rst_an) begin
    if (!rst_an) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else if (start_det) begin
      state_nxt = S_SHIFT;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_IDLE;
        S_SHIFT: begin
          if (byte_end) begin
            if (!fifo_full)     state_nxt = S_ACK;
            else if (STRETCH_EN) state_nxt = S_HOLD;
            else                state_nxt = S_NACK;
          end
        end
        S_HOLD: begin
          if (!fifo_full)    state_nxt = S_ACK;
          else if (hold_tmo) state_nxt = S_NACK;
        end
        S_ACK:   if (bit_vld) state_nxt = S_SHIFT;
        S_NACK:  if (bit_vld) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values for the registered write/overrun outputs. The write decision
  // always uses the current fifo_full, so a strobe is never issued into a full FIFO.
  always_comb begin
    wr_go   = 1'b0;
    ovr_go  = 1'b0;
    wr_data = shreg;
    if (!abort && !start_det) begin
      case (state)
        S_SHIFT: begin
          if (byte_end) begin
            wr_data = {shreg[6:0], bit_in};
            wr_go   = ~fifo_full;
            ovr_go  = fifo_full & ~STRETCH_EN;
          end
        end
        S_HOLD: begin
          wr_go  = ~fifo_full;
          ovr_go = fifo_full & hold_tmo;
        end
        default: begin
          wr_go  = 1'b0;
          ovr_go = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wr_clk or negedge rst_an) begin
    if (!rst_an) begin
      fifo_wr_n <= 1'b1;
      fifo_di   <= 8'h00;
      ack_drv   <= 1'b0;
      scl_hold  <= 1'b0;
      ovr_pulse <= 1'b0;
      ovr_cnt   <= 8'h00;
      busy      <= 1'b0;
    end else begin
      fifo_wr_n <= ~wr_go;
      if (wr_go) fifo_di <= wr_data;
      ack_drv   <= (state_nxt == S_ACK);
      scl_hold  <= (state_nxt == S_HOLD);
      ovr_pulse <= ovr_go;
      busy      <= (state_nxt != S_IDLE);
      if (ovr_clr) begin
        ovr_cnt <= 8'h00;
      end else if (ovr_go && (ovr_cnt != 8'hFF)) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge rst_an) begin
    if (!rst_an) begin
      shreg    <= 8'h00;
      bit_cnt  <= 4'd0;
      hold_cnt <= '0;
    end else begin
      if (abort || start_det) begin
        shreg   <= 8'h00;
        bit_cnt <= 4'd0;
      end else if ((state == S_SHIFT) && bit_vld) begin
        shreg   <= {shreg[6:0], bit_in};
        bit_cnt <= bit_cnt + 4'd1;
      end else if ((state == S_ACK) && bit_vld) begin
        bit_cnt <= 4'd0;
      end
      hold_cnt <= ((state == S_HOLD) && (state_nxt == S_HOLD)) ? hold_cnt + TMO_BITS'(1) : '0;
    end
  end

endmodule

// File: tb/tb_i2c_rxfifo_wrctl.sv
`timescale 1ns/1ps
module tb_i2c_rxfifo_wrctl;

  localparam int NI     = 3;
  localparam int M_IDLE = 0;
  localparam int M_RX   = 1;
  localparam int M_ACK  = 2;
  localparam int M_NACK = 3;

  logic wr_clk = 1'b0;
  logic rst_an = 1'b0;
  logic rx_en = 1'b0, start_det = 1'b0, stop_det = 1'b0;
  logic bit_vld = 1'b0, bit_in = 1'b0, fifo_full = 1'b0, ovr_clr = 1'b0;

  logic       fifo_wr_n [NI];
  logic [7:0] fifo_di   [NI];
  logic       ack_drv   [NI];
  logic       scl_hold  [NI];
  logic       ovr_pulse [NI];
  logic [7:0] ovr_cnt   [NI];
  logic       busy      [NI];

  always #5 wr_clk = ~wr_clk;

  // 0: stretch, short timeout   1: stretch, default timeout   2: no stretch
  i2c_rxfifo_wrctl #(.STRETCH_EN(1'b1), .STRETCH_MAX(8), .TMO_BITS(4)) u_dut_a (
    .wr_clk(wr_clk), .rst_an(rst_an), .rx_en(rx_en), .start_det(start_det),
    .stop_det(stop_det), .bit_vld(bit_vld), .bit_in(bit_in), .fifo_full(fifo_full),
    .fifo_wr_n(fifo_wr_n[0]), .fifo_di(fifo_di[0]), .ack_drv(ack_drv[0]),
    .scl_hold(scl_hold[0]), .ovr_pulse(ovr_pulse[0]), .ovr_clr(ovr_clr),
    .ovr_cnt(ovr_cnt[0]), .busy(busy[0]));

  i2c_rxfifo_wrctl u_dut_b (
    .wr_clk(wr_clk), .rst_an(rst_an), .rx_en(rx_en), .start_det(start_det),
    .stop_det(stop_det), .bit_vld(bit_vld), .bit_in(bit_in), .fifo_full(fifo_full),
    .fifo_wr_n(fifo_wr_n[1]), .fifo_di(fifo_di[1]), .ack_drv(ack_drv[1]),
    .scl_hold(scl_hold[1]), .ovr_pulse(ovr_pulse[1]), .ovr_clr(ovr_clr),
    .ovr_cnt(ovr_cnt[1]), .busy(busy[1]));

  i2c_rxfifo_wrctl #(.STRETCH_EN(1'b0)) u_dut_c (
    .wr_clk(wr_clk), .rst_an(rst_an), .rx_en(rx_en), .start_det(start_det),
    .stop_det(stop_det), .bit_vld(bit_vld), .bit_in(bit_in), .fifo_full(fifo_full),
    .fifo_wr_n(fifo_wr_n[2]), .fifo_di(fifo_di[2]), .ack_drv(ack_drv[2]),
    .scl_hold(scl_hold[2]), .ovr_pulse(ovr_pulse[2]), .ovr_clr(ovr_clr),
    .ovr_cnt(ovr_cnt[2]), .busy(busy[2]));

  // Reference model: protocol position per instance plus expected FIFO contents.
  int         m_en  [NI] = '{1, 1, 0};
  int         m_max [NI] = '{8, 1023, 1023};
  int         st    [NI] = '{0, 0, 0};
  int         nbits [NI] = '{0, 0, 0};
  logic [7:0] sh    [NI];
  int         exp_ovr  [NI] = '{0, 0, 0};
  int         exp_cnt  [NI] = '{0, 0, 0};
  int         exp_hold [NI] = '{0, 0, 0};
  logic [7:0] exp_mem  [NI][4096];
  int         wr_idx   [NI] = '{0, 0, 0};
  int         rd_idx   [NI] = '{0, 0, 0};
  int         wr_seen  [NI] = '{0, 0, 0};
  int         wr_extra [NI] = '{0, 0, 0};
  int         ovr_seen [NI] = '{0, 0, 0};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_push(input int i, input logic [7:0] b);
    exp_mem[i][wr_idx[i] % 4096] = b;
    wr_idx[i]++;
  endtask

  task automatic m_drop(input int i);
    exp_ovr[i]++;
    if (exp_cnt[i] < 255) exp_cnt[i]++;
  endtask

  // f: FIFO full at byte end; k: cycles it stays full (counting the byte-end cycle)
  task automatic m_bit(input logic b, input logic f, input int k);
    for (int i = 0; i < NI; i++) begin
      exp_hold[i] = 0;
      case (st[i])
        M_RX: begin
          sh[i] = {sh[i][6:0], b};
          nbits[i]++;
          if (nbits[i] == 8) begin
            if (!f) begin
              m_push(i, sh[i]); st[i] = M_ACK;
            end else if (m_en[i] != 0 && k <= m_max[i]) begin
              exp_hold[i] = k; m_push(i, sh[i]); st[i] = M_ACK;
            end else begin
              exp_hold[i] = (m_en[i] != 0) ? m_max[i] : 0;
              m_drop(i); st[i] = M_NACK;
            end
          end
        end
        M_ACK:   begin st[i] = M_RX; nbits[i] = 0; end
        M_NACK:  st[i] = M_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic m_start();
    if (rx_en) for (int i = 0; i < NI; i++) begin st[i] = M_RX; nbits[i] = 0; sh[i] = 8'h00; end
  endtask

  task automatic m_idle();
    for (int i = 0; i < NI; i++) st[i] = M_IDLE;
  endtask

  always @(negedge wr_clk) begin
    if (rst_an) begin
      for (int i = 0; i < NI; i++) begin
        if (fifo_wr_n[i] == 1'b0) begin
          wr_seen[i]++;
          if (rd_idx[i] < wr_idx[i]) begin
            chk($sformatf("wr_data%0d", i), fifo_di[i], exp_mem[i][rd_idx[i] % 4096]);
            rd_idx[i]++;
          end else begin
            wr_extra[i]++;
          end
        end
        if (ovr_pulse[i] == 1'b1) ovr_seen[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic check_status();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ack%0d", i), ack_drv[i], (st[i] == M_ACK) ? 1 : 0);
      chk($sformatf("busy%0d", i), busy[i], (st[i] != M_IDLE) ? 1 : 0);
      chk($sformatf("hold%0d", i), scl_hold[i], 0);
      chk($sformatf("ovr_cnt%0d", i), ovr_cnt[i], exp_cnt[i]);
    end
  endtask

  task automatic txn_check();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("wr_count%0d", i), wr_seen[i], wr_idx[i]);
      chk($sformatf("wr_extra%0d", i), wr_extra[i], 0);
      chk($sformatf("ovr_pulses%0d", i), ovr_seen[i], exp_ovr[i]);
    end
  endtask

  task automatic do_start();
    start_det = 1'b1; tick(); start_det = 1'b0;
    m_start(); check_status();
  endtask

  task automatic do_stop();
    stop_det = 1'b1; tick(); stop_det = 1'b0;
    m_idle(); check_status();
  endtask

  task automatic send_bit(input logic b, input logic f, input int k);
    int hc [NI];
    m_bit(b, f, k);
    bit_vld = 1'b1; bit_in = b; fifo_full = f;
    tick();
    bit_vld = 1'b0; bit_in = 1'b0;
    if (f) begin
      for (int i = 0; i < NI; i++) hc[i] = 0;
      for (int j = 1; j <= k; j++) begin
        for (int i = 0; i < NI; i++) if (scl_hold[i]) hc[i]++;
        if (j == k) fifo_full = 1'b0;
        tick();
      end
      for (int i = 0; i < NI; i++) chk($sformatf("hold_len%0d", i), hc[i], exp_hold[i]);
      check_status();
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic f, input int k);
    logic [7:0] v;
    v = d;
    for (int n = 7; n >= 0; n--) begin
      send_bit(v[n], (n == 0) ? f : 1'b0, k);
      if (n != 0) gap();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int nb, p;

    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_wr_n%0d", i), fifo_wr_n[i], 1);
      chk($sformatf("rst_di%0d", i), fifo_di[i], 0);
      chk($sformatf("rst_ack%0d", i), ack_drv[i], 0);
      chk($sformatf("rst_hold%0d", i), scl_hold[i], 0);
      chk($sformatf("rst_ovr%0d", i), ovr_pulse[i], 0);
      chk($sformatf("rst_cnt%0d", i), ovr_cnt[i], 0);
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
    end
    rst_an = 1'b1; rx_en = 1'b1;
    tick();

    // single byte 0xA5, write strobe exactly one cycle after the 8th bit
    do_start();
    d = 8'hA5;
    for (int n = 7; n >= 1; n--) send_bit(d[n], 1'b0, 0);
    chk("pre_wr", fifo_wr_n[0], 1);
    send_bit(d[0], 1'b0, 0);
    chk("a5_wr_n", fifo_wr_n[0], 0);
    chk("a5_di", fifo_di[0], 8'hA5);
    chk("a5_ack", ack_drv[0], 1);
    tick();
    chk("a5_wr_end", fifo_wr_n[0], 1);
    chk("a5_ack_hold", ack_drv[0], 1);
    send_bit(1'b0, 1'b0, 0);
    check_status();
    do_stop();
    tick(); txn_check();

    // three back-to-back bytes then STOP
    do_start();
    for (int b = 1; b <= 3; b++) begin
      send_byte(8'(b), 1'b0, 0);
      send_bit(1'b0, 1'b0, 0);
      check_status();
    end
    do_stop();
    tick(); txn_check();

    // full for 20 cycles: long-timeout part stretches 20, short one times out
    do_start();
    send_byte(8'h5A, 1'b1, 20);
    send_bit(1'b0, 1'b0, 0);
    check_status();
    do_stop();
    tick(); txn_check();

    // full for 12 cycles: 8-cycle stretch then NACK and IDLE after the 9th bit
    do_start();
    send_byte(8'hC3, 1'b1, 12);
    send_bit(1'b1, 1'b0, 0);
    check_status();
    do_stop();
    tick(); txn_check();

    // repeated START mid-byte, then STOP mid-byte
    do_start();
    for (int n = 0; n < 5; n++) send_bit(1'b1, 1'b0, 0);
    do_start();
    send_byte(8'h3C, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    for (int n = 0; n < 3; n++) send_bit(1'b1, 1'b0, 0);
    do_stop();
    tick(); txn_check();

    // rx_en low aborts a byte; START is ignored while disabled
    do_start();
    for (int n = 0; n < 4; n++) send_bit(1'b0, 1'b0, 0);
    rx_en = 1'b0; tick(); m_idle(); check_status();
    do_start();
    for (int n = 0; n < 4; n++) send_bit(1'b1, 1'b0, 0);
    check_status();
    rx_en = 1'b1;
    tick(); txn_check();

    // randomized transfers
    for (int t = 0; t < 50; t++) begin
      do_start();
      nb = $urandom_range(1, 3);
      for (int n = 0; n < nb; n++) begin
        if ($urandom_range(0, 6) == 0) begin
          p = $urandom_range(1, 7);
          for (int q = 0; q < p; q++) begin send_bit(1'($urandom), 1'b0, 0); gap(); end
          if ($urandom_range(0, 1) == 0) do_start(); else do_stop();
        end else begin
          send_byte(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(1, 12));
          gap();
          send_bit(1'($urandom), 1'b0, 0);
          gap();
        end
      end
      do_stop();
      tick(); txn_check();
    end

    // 256 drops: counters saturate at 255
    for (int n = 0; n < 256; n++) begin
      do_start();
      send_byte(8'(n), 1'b1, 10);
      send_bit(1'b1, 1'b0, 0);
      do_stop();
    end
    chk("sat_a", ovr_cnt[0], 255);
    chk("sat_c", ovr_cnt[2], 255);
    tick(); txn_check();

    // ovr_clr coincident with the drop decision wins over the increment
    do_start();
    d = 8'h77;
    for (int n = 7; n >= 1; n--) send_bit(d[n], 1'b0, 0);
    m_bit(d[0], 1'b1, 10);
    bit_vld = 1'b1; bit_in = d[0]; fifo_full = 1'b1; ovr_clr = 1'b1;
    tick();
    bit_vld = 1'b0; ovr_clr = 1'b0;
    chk("clr_pulse_c", ovr_pulse[2], 1);
    chk("clr_cnt_c", ovr_cnt[2], 0);
    chk("clr_cnt_a", ovr_cnt[0], 0);
    repeat (7) tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("clr_pulse_a", ovr_pulse[0], 1);
    chk("clr_cnt_a2", ovr_cnt[0], 0);
    tick();
    fifo_full = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) exp_cnt[i] = 0;
    check_status();
    send_bit(1'b0, 1'b0, 0);
    do_stop();
    do_start();
    send_byte(8'h99, 1'b1, 10);
    send_bit(1'b1, 1'b0, 0);
    do_stop();
    tick(); txn_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
